serial_adder_ctrl: RTL and testbench

Bit-serial adder sequencer that time-shares one external 1-bit full adder across a WIDTH-bit addition. It latches two operands and a carry-in on a start request, then feeds the full adder one bit pair per clock, LSB first, with a registered carry loop. It collects sum bits into a result register and signals completion with a one-cycle done pulse. It sits between a requesting datapath and the single `Full_Adder` instance, which is wired externally through the `fa_*` ports.

---
 rtl/serial_adder_ctrl.sv | 104 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer driving one external full adder, LSB first, done pulse WIDTH cycles after start.
// Optional signed-overflow flag (ovf port) is built only when SERIAL_ADDER_OVF_EN is defined.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c0,
    input  logic             fa_s,
    input  logic             fa_c
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;

    // Adder inputs are gated by state so they sit at 0 outside RUN.
    assign fa_a  = (state == RUN) && a_sh[0];
    assign fa_b  = (state == RUN) && b_sh[0];
    assign fa_c0 = (state == RUN) && carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            sum   <= '0;
            c_out <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        carry <= c_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        done  <= 1'b1;
                        c_out <= fa_c;
`ifdef SERIAL_ADDER_OVF_EN
                        // Carry into the MSB differs from carry out of it.
                        ovf   <= fa_c ^ fa_c0;
`endif
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 and WIDTH=2 instances, each with a modelled external full adder.
module tb_serial_adder_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       st8 = 1'b0, ci8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       busy8, done8, co8, fa8_a, fa8_b, fa8_c0, fa8_s, fa8_c;
    logic       st2 = 1'b0, ci2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0, sum2;
    logic       busy2, done2, co2, fa2_a, fa2_b, fa2_c0, fa2_s, fa2_c;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8, ovf2;
`endif

    assign fa8_s = fa8_a ^ fa8_b ^ fa8_c0;
    assign fa8_c = (fa8_a & fa8_b) | (fa8_a & fa8_c0) | (fa8_b & fa8_c0);
    assign fa2_s = fa2_a ^ fa2_b ^ fa2_c0;
    assign fa2_c = (fa2_a & fa2_b) | (fa2_a & fa2_c0) | (fa2_b & fa2_c0);

    serial_adder_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(st8), .a_in(a8), .b_in(b8), .c_in(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(co8),
        .fa_a(fa8_a), .fa_b(fa8_b), .fa_c0(fa8_c0), .fa_s(fa8_s), .fa_c(fa8_c)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf8)
`endif
    );

    serial_adder_ctrl #(.WIDTH(2)) u2 (
        .clk(clk), .rst(rst), .start(st2), .a_in(a2), .b_in(b2), .c_in(ci2),
        .busy(busy2), .done(done2), .sum(sum2), .c_out(co2),
        .fa_a(fa2_a), .fa_b(fa2_b), .fa_c0(fa2_c0), .fa_s(fa2_s), .fa_c(fa2_c)
`ifdef SERIAL_ADDER_OVF_EN
        , .ovf(ovf2)
`endif
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition and sign-rule overflow.
    function automatic logic ref_ovf(input logic sa, input logic sb, input logic ss);
        return (sa == sb) && (ss != sa);
    endfunction

    // Called at a negedge with u8 idle; returns at a negedge with u8 idle again.
    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c);
        logic [8:0] r;
        int done_at, busy_n, done_n;
        logic [7:0] s_d;
        logic co_d, ov_d;
        r = 9'(a) + 9'(b) + 9'(c);
        done_at = -1; busy_n = 0; done_n = 0; s_d = '0; co_d = 1'b0; ov_d = 1'b0;
        a8 = a; b8 = b; ci8 = c; st8 = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (n == 1) begin
                st8 = 1'b0; a8 = ~a; b8 = 8'($urandom); ci8 = ~c;
            end
            if (busy8) busy_n++;
            if (done8) begin
                done_n++;
                if (done_at < 0) begin
                    done_at = n; s_d = sum8; co_d = co8;
`ifdef SERIAL_ADDER_OVF_EN
                    ov_d = ovf8;
`endif
                end
            end
        end
        check({tag, "/done_cycle"}, 64'(done_at), 64'(9));
        check({tag, "/done_count"}, 64'(done_n), 64'(1));
        check({tag, "/busy_cycles"}, 64'(busy_n), 64'(9));
        check({tag, "/sum"}, 64'(s_d), 64'(r[7:0]));
        check({tag, "/c_out"}, 64'(co_d), 64'(r[8]));
        check({tag, "/sum_held"}, 64'(sum8), 64'(r[7:0]));
        check({tag, "/c_out_held"}, 64'(co8), 64'(r[8]));
`ifdef SERIAL_ADDER_OVF_EN
        check({tag, "/ovf"}, 64'(ov_d), 64'(ref_ovf(a[7], b[7], r[7])));
`endif
    endtask

    task automatic op2(input logic [1:0] a, input logic [1:0] b, input logic c);
        logic [2:0] r;
        int done_at;
        logic [1:0] s_d;
        logic co_d, ov_d;
        r = 3'(a) + 3'(b) + 3'(c);
        done_at = -1; s_d = '0; co_d = 1'b0; ov_d = 1'b0;
        a2 = a; b2 = b; ci2 = c; st2 = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (n == 1) begin
                st2 = 1'b0; a2 = ~a; b2 = ~b;
            end
            if (done2 && done_at < 0) begin
                done_at = n; s_d = sum2; co_d = co2;
`ifdef SERIAL_ADDER_OVF_EN
                ov_d = ovf2;
`endif
            end
        end
        check($sformatf("w2 %0d+%0d+%0d/done_cycle", a, b, c), 64'(done_at), 64'(3));
        check($sformatf("w2 %0d+%0d+%0d/sum", a, b, c), 64'({co_d, s_d}), 64'(r));
        check($sformatf("w2 %0d+%0d+%0d/held", a, b, c), 64'({co2, sum2}), 64'(r));
`ifdef SERIAL_ADDER_OVF_EN
        check($sformatf("w2 %0d+%0d+%0d/ovf", a, b, c), 64'(ov_d), 64'(ref_ovf(a[1], b[1], r[1])));
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int dn, d1, d2, idle_busy, stray;
        logic [8:0] s1, s2;

        // Reset state.
        #1 rst = 1'b1;
        #1;
        check("rst/busy", 64'(busy8), 64'(0));
        check("rst/done", 64'(done8), 64'(0));
        check("rst/sum_cout", 64'({co8, sum8}), 64'(0));
        check("rst/fa", 64'({fa8_a, fa8_b, fa8_c0}), 64'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        op8("0f+01", 8'h0F, 8'h01, 1'b0);
        op8("ff+01", 8'hFF, 8'h01, 1'b0);
        op8("ff+ff+1", 8'hFF, 8'hFF, 1'b1);
        op8("7f+01", 8'h7F, 8'h01, 1'b0);
        op8("80+80", 8'h80, 8'h80, 1'b0);
        op8("10+20", 8'h10, 8'h20, 1'b0);

        // start held high across two operations; operands changed mid-run.
        a8 = 8'h3C; b8 = 8'h55; ci8 = 1'b0; st8 = 1'b1;
        dn = 0; d1 = -1; d2 = -1; idle_busy = 1; s1 = '0; s2 = '0;
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            if (n == 4) begin a8 = 8'hA1; b8 = 8'h0E; ci8 = 1'b1; end
            if (n == 10) idle_busy = int'(busy8);
            if (done8) begin
                dn++;
                if (d1 < 0) begin d1 = n; s1 = {co8, sum8}; end
                else if (d2 < 0) begin d2 = n; s2 = {co8, sum8}; end
            end
            if (n == 19) st8 = 1'b0;
        end
        check("hold/done_count", 64'(dn), 64'(2));
        check("hold/first_done", 64'(d1), 64'(9));
        check("hold/second_done", 64'(d2), 64'(19));
        check("hold/idle_gap", 64'(idle_busy), 64'(0));
        check("hold/first_sum", 64'(s1), 64'(9'h03C + 9'h055));
        check("hold/second_sum", 64'(s2), 64'(9'h0A1 + 9'h00E + 9'h001));

        // Asynchronous reset in the middle of bit 4.
        a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; st8 = 1'b1;
        @(negedge clk);
        st8 = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst/pre_busy", 64'(busy8), 64'(1));
        check("midrst/pre_fa_a", 64'(fa8_a), 64'(1));
        #2 rst = 1'b1;
        #1;
        check("midrst/busy", 64'(busy8), 64'(0));
        check("midrst/done", 64'(done8), 64'(0));
        check("midrst/sum_cout", 64'({co8, sum8}), 64'(0));
        check("midrst/fa", 64'({fa8_a, fa8_b, fa8_c0}), 64'(0));
`ifdef SERIAL_ADDER_OVF_EN
        check("midrst/ovf", 64'(ovf8), 64'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (done8 || busy8) stray++;
        end
        check("midrst/no_done", 64'(stray), 64'(0));
        op8("after_rst", 8'h12, 8'h34, 1'b0);

        for (int i = 0; i < 16; i++)
            op8($sformatf("rand%0d", i), 8'($urandom), 8'($urandom), 1'($urandom));

        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++)
                for (int c = 0; c < 2; c++)
                    op2(2'(a), 2'(b), 1'(c));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
